adpcm_main_mul_pipe_sgn: RTL and testbench
==========================================

Name: adpcm_main_mul_pipe_sgn

Overview:
Parametrised, pipelined, mode-selectable integer multiplier for the ADPCM datapath. It is the successor to the fixed-width, purely combinational unsigned multiplier wrappers. Operand widths, output width and pipeline depth are parameters. Signedness is chosen per transaction. Issue is tagged with a valid bit and the pipeline stalls on a clock enable, so the HLS scheduler can bind one instance across a multi-cycle schedule.

Parameters:
ID, 1, instance identifier; no functional effect.
NUM_STAGE, 3, pipeline latency in enabled cycles; legal range 1..8.
din0_WIDTH, 15, width of operand A.
din1_WIDTH, 11, width of operand B.
dout_WIDTH, 27, result width; may be smaller than, equal to, or larger than din0_WIDTH+din1_WIDTH.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  synchronous reset, active-high.
ce  in  1  clock enable; pipeline advances only when 1.
in_vld  in  1  operands valid this cycle.
mode  in  2  bit0=1: din0 signed; bit1=1: din1 signed.
din0  in  din0_WIDTH  operand A.
din1  in  din1_WIDTH  operand B.
dout  out  dout_WIDTH  product.
out_vld  out  1  dout holds a completed product.

Behaviour:
- Reset: synchronous, active-high, and it has priority over ce. On a reset edge, all valid stage bits clear, out_vld goes to 0 and dout goes to 0. Operations in flight are discarded and never produce out_vld.
- Issue: an operation is accepted on a rising edge where reset=0, ce=1 and in_vld=1. din0, din1 and mode are sampled on that same edge.
- ce=0: every register holds, including valid bits, data, out_vld and dout. in_vld is ignored.
- Latency: a product issued on enabled edge k appears with out_vld=1 after the NUM_STAGE-th enabled edge counted from edge k (edge k counts as the first). With ce held at 1 this is exactly NUM_STAGE cycles. Back-to-back issue gives one result per enabled cycle, and results leave in issue order.
- Bubbles: an enabled edge with in_vld=0 inserts a bubble, so out_vld=0 for that slot NUM_STAGE enabled edges later. On a bubble slot dout holds its previous value.
- Arithmetic:
  - Each operand is extended by one bit: sign-extended if its mode bit is 1, zero-extended otherwise.
  - The extended operands are multiplied as signed, giving a (din0_WIDTH+din1_WIDTH+2)-bit exact product.
  - If dout_WIDTH is smaller, dout takes the low dout_WIDTH bits (wrap, no saturation).
  - If dout_WIDTH is larger, the product is sign-extended from the exact product.
  - In mode=00 the exact product is non-negative, so the extension is zeros.
- Stage structure: stage 1 registers the extended operands plus valid. The multiply sits between stage 1 and stage 2, and stages 2..NUM_STAGE carry the product plus valid. For NUM_STAGE=1 the multiply is combinational from the inputs into the single output register.
- No backpressure: the consumer must take dout while out_vld=1 and ce=1. On the next enabled edge out_vld/dout are overwritten or cleared by the following slot.
- ce=1 with reset=1: reset wins.

Decomposition:
- Package adpcm_mul_pkg holds:
  - mode constants MODE_UU=2'b00, MODE_SU=2'b01, MODE_US=2'b10, MODE_SS=2'b11;
  - constant MUL_MAX_STAGE=8;
  - function prod_width(a,b)=a+b+2.
- Sub-module adpcm_main_mul_pipe_sgn_core: combinational signed (din0_WIDTH+1)x(din1_WIDTH+1) multiplier, kept as a separate module for DSP inference.
- The top level contains the valid/data shift pipeline, the ce gating and the output width adaptation.

Test Plan:
- Unsigned max: NUM_STAGE=3, mode=00, din0=0x7FFF, din1=0x7FF, ce=1 -> out_vld=1 on the 3rd edge after issue, dout=0x3FF7801.
- Signed/mixed: mode=01, din0=0x7FFD(-3), din1=5 -> dout=0x7FFFFF1. mode=11, din0=0x4000, din1=0x400 -> dout=0x1000000. mode=10, din0=2, din1=0x7FF -> dout=0x7FFFFFE. Same operands with mode=00 -> dout=4094.
- Streaming: issue 1x1, 2x2, bubble, 3x3 on consecutive cycles -> out_vld pattern 1,1,0,1 starting 3 cycles later, with dout 1,4,(held 4),9.
- Stall: issue at edge 0, ce=0 on edges 1-2, ce=1 thereafter -> out_vld asserts on edge 4 (not edge 2). dout and out_vld stay stable while ce=0.
- Reset mid-flight: issue two ops, assert reset for one cycle on the next edge, with ce=0 or 1 -> out_vld stays 0 for the following 5 cycles and dout=0.
- Width adaptation: dout_WIDTH=16, mode=00, 0x7FFF x 0x7FF -> dout=0x7801. dout_WIDTH=32, mode=11, -3x5 -> dout=0xFFFFFFF1.

Source files
------------

// File: rtl/adpcm_mul_pkg.sv
// rtl/adpcm_mul_pkg.sv - shared constants and helpers for the ADPCM pipelined multiplier
package adpcm_mul_pkg;

    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_US = 2'b10;
    localparam logic [1:0] MODE_SS = 2'b11;

    localparam int MUL_MAX_STAGE = 8;

    // Exact product width of two operands after each gains one extension bit.
    function automatic int prod_width(input int a, input int b);
        return a + b + 2;
    endfunction

endpackage

// File: rtl/adpcm_main_mul_pipe_sgn_core.sv
// rtl/adpcm_main_mul_pipe_sgn_core.sv - combinational signed multiplier kept apart for DSP inference
module adpcm_main_mul_pipe_sgn_core #(
    parameter int A_W = 16,
    parameter int B_W = 12
) (
    input  logic signed [A_W-1:0]     a_i,
    input  logic signed [B_W-1:0]     b_i,
    output logic signed [A_W+B_W-1:0] p_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] a_w;
    logic signed [P_W-1:0] b_w;

    assign a_w = a_i;
    assign b_w = b_i;
    assign p_o = a_w * b_w;

endmodule

// File: rtl/adpcm_main_mul_pipe_sgn.sv
// rtl/adpcm_main_mul_pipe_sgn.sv - pipelined mode-selectable multiplier with valid tagging and clock enable
module adpcm_main_mul_pipe_sgn
    import adpcm_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 15,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic [1:0]            mode,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_vld
);

    localparam int PW        = prod_width(din0_WIDTH, din1_WIDTH);
    localparam int unused_id = ID;

    logic                         a_sgn;
    logic                         b_sgn;
    logic signed [din0_WIDTH:0]   a_ext;
    logic signed [din1_WIDTH:0]   b_ext;
    logic signed [din0_WIDTH:0]   a_mul;
    logic signed [din1_WIDTH:0]   b_mul;
    logic                         mul_vld;
    logic signed [PW-1:0]         prod;
    logic [PW-1:0]                fin_prod;
    logic                         fin_vld;
    logic [dout_WIDTH-1:0]        dout_d;
    logic [dout_WIDTH-1:0]        dout_q;
    logic                         out_vld_q;

    assign a_sgn = (mode == MODE_SU) || (mode == MODE_SS);
    assign b_sgn = (mode == MODE_US) || (mode == MODE_SS);
    assign a_ext = {a_sgn & din0[din0_WIDTH-1], din0};
    assign b_ext = {b_sgn & din1[din1_WIDTH-1], din1};

    // A single-stage pipe multiplies straight from the ports into the output register.
    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign a_mul   = a_ext;
            assign b_mul   = b_ext;
            assign mul_vld = in_vld;
        end else begin : g_s1
            logic signed [din0_WIDTH:0] a_q;
            logic signed [din1_WIDTH:0] b_q;
            logic                       s1_vld_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_vld_q <= 1'b0;
                    a_q      <= '0;
                    b_q      <= '0;
                end else if (ce) begin
                    s1_vld_q <= in_vld;
                    if (in_vld) begin
                        a_q <= a_ext;
                        b_q <= b_ext;
                    end
                end
            end

            assign a_mul   = a_q;
            assign b_mul   = b_q;
            assign mul_vld = s1_vld_q;
        end
    endgenerate

    adpcm_main_mul_pipe_sgn_core #(
        .A_W (din0_WIDTH + 1),
        .B_W (din1_WIDTH + 1)
    ) u_core (
        .a_i (a_mul),
        .b_i (b_mul),
        .p_o (prod)
    );

    generate
        if (NUM_STAGE > 2) begin : g_mid
            localparam int MID = NUM_STAGE - 2;

            logic [PW-1:0]  mid_q [MID];
            logic [MID-1:0] mid_vld_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    mid_vld_q <= '0;
                    for (int i = 0; i < MID; i++) begin
                        mid_q[i] <= '0;
                    end
                end else if (ce) begin
                    mid_vld_q[0] <= mul_vld;
                    mid_q[0]     <= prod;
                    for (int i = 1; i < MID; i++) begin
                        mid_vld_q[i] <= mid_vld_q[i-1];
                        mid_q[i]     <= mid_q[i-1];
                    end
                end
            end

            assign fin_vld  = mid_vld_q[MID-1];
            assign fin_prod = mid_q[MID-1];
        end else begin : g_nomid
            assign fin_vld  = mul_vld;
            assign fin_prod = prod;
        end
    endgenerate

    // Narrow outputs wrap; wide outputs sign-extend the exact product.
    generate
        if (dout_WIDTH <= PW) begin : g_trunc
            assign dout_d = fin_prod[dout_WIDTH-1:0];
            if (dout_WIDTH < PW) begin : g_hi
                logic unused_hi;
                assign unused_hi = ^fin_prod[PW-1:dout_WIDTH];
            end
        end else begin : g_sext
            assign dout_d = {{(dout_WIDTH - PW){fin_prod[PW-1]}}, fin_prod};
        end
    endgenerate

    // Bubble slots leave dout untouched so the last product stays visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
        end else if (ce) begin
            out_vld_q <= fin_vld;
            if (fin_vld) begin
                dout_q <= dout_d;
            end
        end
    end

    assign dout    = dout_q;
    assign out_vld = out_vld_q;

endmodule

// File: tb/tb_adpcm_main_mul_pipe_sgn.sv
// tb/tb_adpcm_main_mul_pipe_sgn.sv - self-checking bench for the pipelined signed multiplier
module tb_adpcm_main_mul_pipe_sgn;

    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_vld;
    logic [1:0]  mode;
    logic [14:0] din0;
    logic [10:0] din1;
    logic [26:0] dout27;
    logic [15:0] dout16;
    logic [31:0] dout32;
    logic        v27;
    logic        v16;
    logic        v32;
    logic        mon_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    adpcm_main_mul_pipe_sgn #(.ID(1), .NUM_STAGE(NS), .din0_WIDTH(15), .din1_WIDTH(11), .dout_WIDTH(27)) u27 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .mode(mode),
        .din0(din0), .din1(din1), .dout(dout27), .out_vld(v27)
    );

    adpcm_main_mul_pipe_sgn #(.ID(2), .NUM_STAGE(NS), .din0_WIDTH(15), .din1_WIDTH(11), .dout_WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .mode(mode),
        .din0(din0), .din1(din1), .dout(dout16), .out_vld(v16)
    );

    adpcm_main_mul_pipe_sgn #(.ID(3), .NUM_STAGE(NS), .din0_WIDTH(15), .din1_WIDTH(11), .dout_WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .mode(mode),
        .din0(din0), .din1(din1), .dout(dout32), .out_vld(v32)
    );

    typedef struct {
        logic        vld;
        logic [14:0] a;
        logic [10:0] b;
        logic [1:0]  m;
    } slot_t;

    slot_t       sq[$];
    logic        exp_vld = 1'b0;
    logic [63:0] exp27   = '0;
    logic [63:0] exp16   = '0;
    logic [63:0] exp32   = '0;

    function automatic logic [63:0] model(input logic [14:0] a, input logic [10:0] b,
                                          input logic [1:0] m, input int w);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] r;
        sa = m[0] ? longint'($signed(a)) : longint'(a);
        sb = m[1] ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        r  = p;
        r  = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One slot per enabled edge; the slot leaving the queue is the one at the output.
    always @(posedge clk) begin
        slot_t s;
        if (reset) begin
            sq.delete();
            exp_vld = 1'b0;
            exp27   = '0;
            exp16   = '0;
            exp32   = '0;
        end else if (ce) begin
            s.vld = in_vld;
            s.a   = din0;
            s.b   = din1;
            s.m   = mode;
            sq.push_back(s);
            if (sq.size() == NS) begin
                s       = sq.pop_front();
                exp_vld = s.vld;
                if (s.vld) begin
                    exp27 = model(s.a, s.b, s.m, 27);
                    exp16 = model(s.a, s.b, s.m, 16);
                    exp32 = model(s.a, s.b, s.m, 32);
                end
            end else begin
                exp_vld = 1'b0;
            end
        end
        @(negedge clk);
        if (mon_en) begin
            check("sb_vld27", 64'(v27), 64'(exp_vld));
            check("sb_vld16", 64'(v16), 64'(exp_vld));
            check("sb_vld32", 64'(v32), 64'(exp_vld));
            check("sb_dout27", 64'(dout27), exp27);
            check("sb_dout16", 64'(dout16), exp16);
            check("sb_dout32", 64'(dout32), exp32);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [14:0] a, input logic [10:0] b, input logic [1:0] m);
        in_vld = 1'b1;
        din0   = a;
        din1   = b;
        mode   = m;
    endtask

    task automatic idle();
        in_vld = 1'b0;
        din0   = '0;
        din1   = '0;
        mode   = 2'b00;
    endtask

    initial begin
        reset  = 1'b1;
        ce     = 1'b1;
        idle();
        tick();
        tick();
        check("rst_vld", 64'(v27), 64'd0);
        check("rst_dout", 64'(dout27), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        drive(15'h7FFF, 11'h7FF, 2'b00);
        tick();
        idle();
        tick();
        check("umax_early_vld", 64'(v27), 64'd0);
        tick();
        check("umax_vld", 64'(v27), 64'd1);
        check("umax_dout27", 64'(dout27), 64'h3FF7801);
        check("umax_dout16", 64'(dout16), 64'h7801);
        check("umax_dout32", 64'(dout32), 64'h3FF7801);

        drive(15'h7FFD, 11'd5, 2'b01);
        tick();
        drive(15'h4000, 11'h400, 2'b11);
        tick();
        drive(15'd2, 11'h7FF, 2'b10);
        tick();
        check("su_dout27", 64'(dout27), 64'h7FFFFF1);
        check("su_dout32", 64'(dout32), 64'hFFFFFFF1);
        drive(15'd2, 11'h7FF, 2'b00);
        tick();
        check("ss_dout27", 64'(dout27), 64'h1000000);
        idle();
        tick();
        check("us_dout27", 64'(dout27), 64'h7FFFFFE);
        tick();
        check("uu_dout27", 64'(dout27), 64'd4094);
        tick();

        drive(15'd1, 11'd1, 2'b00);
        tick();
        drive(15'd2, 11'd2, 2'b00);
        tick();
        idle();
        tick();
        check("str0_vld", 64'(v27), 64'd1);
        check("str0_dout", 64'(dout27), 64'd1);
        drive(15'd3, 11'd3, 2'b00);
        tick();
        check("str1_vld", 64'(v27), 64'd1);
        check("str1_dout", 64'(dout27), 64'd4);
        idle();
        tick();
        check("str2_vld", 64'(v27), 64'd0);
        check("str2_dout_held", 64'(dout27), 64'd4);
        tick();
        check("str3_vld", 64'(v27), 64'd1);
        check("str3_dout", 64'(dout27), 64'd9);
        tick();

        drive(15'd7, 11'd6, 2'b00);
        tick();
        ce = 1'b0;
        drive(15'd100, 11'd100, 2'b11);
        tick();
        check("stall1_vld", 64'(v27), 64'd0);
        check("stall1_dout", 64'(dout27), 64'd9);
        tick();
        check("stall2_vld", 64'(v27), 64'd0);
        ce = 1'b1;
        idle();
        tick();
        check("stall3_vld", 64'(v27), 64'd0);
        tick();
        check("stall4_vld", 64'(v27), 64'd1);
        check("stall4_dout", 64'(dout27), 64'd42);

        drive(15'd10, 11'd10, 2'b00);
        tick();
        idle();
        tick();
        tick();
        check("hold0_vld", 64'(v27), 64'd1);
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_vld", 64'(v27), 64'd1);
            check("hold_dout", 64'(dout27), 64'd100);
        end
        ce = 1'b1;
        tick();
        check("hold_end_vld", 64'(v27), 64'd0);
        check("hold_end_dout", 64'(dout27), 64'd100);

        for (int c = 0; c < 2; c++) begin
            drive(15'd5, 11'd5, 2'b00);
            tick();
            drive(15'd6, 11'd6, 2'b00);
            tick();
            idle();
            reset = 1'b1;
            ce    = (c == 1);
            tick();
            reset = 1'b0;
            ce    = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                check("rstmid_vld", 64'(v27), 64'd0);
                check("rstmid_dout", 64'(dout27), 64'd0);
            end
        end

        drive(15'h7FFD, 11'd5, 2'b11);
        tick();
        idle();
        tick();
        tick();
        check("ss_neg_dout32", 64'(dout32), 64'hFFFFFFF1);
        check("ss_neg_dout16", 64'(dout16), 64'hFFF1);
        tick();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
